issue_ctrl: RTL and testbench
=============================

Name: issue_ctrl

Overview:
- Issue/stall controller between the instruction decoder and the execute stage of the RV32IM core.
- Consumes the decoder's register fields and valid flags, keeps a 32-entry register scoreboard, and detects RAW hazards against in-flight writes.
- Serialises the shared multi-cycle mul/div unit, which accepts one operation at a time.
- Presents a registered, valid/ready issue slot to execute.

Parameters:
- MUL_LAT, 4: cycles the mul/div unit is occupied by MUL/MULH/MULHSU/MULHU.
- DIV_LAT, 33: cycles occupied by DIV/DIVU/REM/REMU.
- CNT_W, 6: width of the mul/div occupancy counter; must hold DIV_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  decoder holds an instruction.
- id_ready  out  1  controller accepts it this cycle.
- rs1_addr  in  5  source 1 index.
- rs1_valid  in  1  rs1 used.
- rs2_addr  in  5  source 2 index.
- rs2_valid  in  1  rs2 used.
- rd_addr  in  5  destination index.
- rd_valid  in  1  rd written.
- is_muldiv  in  1  M-extension op (opcode 0110011, func7 0000001).
- is_div  in  1  func3[2] of an M op (div/rem class).
- ex_valid  out  1  registered issue slot valid.
- ex_ready  in  1  execute accepts slot.
- ex_rd  out  5  registered rd (0 if !rd_valid).
- ex_muldiv  out  1  registered is_muldiv.
- md_start  out  1  one-cycle pulse: launch mul/div unit.
- md_busy  out  1  mul/div unit occupied.
- wb_valid  in  1  writeback occurring.
- wb_rd  in  5  writeback index.
- flush  in  1  branch/jump redirect, squash.
- pending  out  32  scoreboard bits (bit0 always 0).
- stall_cycles  out  32  saturating count of cycles with id_valid && !id_ready.

Behaviour:
- Reset (rst=1 at an edge):
  - ex_valid=0, ex_rd=0, ex_muldiv=0, md_start=0, md_busy=0.
  - pending=0, stall_cycles=0; FSM goes to RUN.
  - Reset mid-division aborts the division with no done or writeback effect.
- Hazard term per source s:
  - s_valid && s_addr!=0 && pending[s_addr] && !(wb_valid && wb_rd==s_addr).
  - Writeback in the same cycle bypasses the hazard.
- WAW: rd_valid && rd_addr!=0 && pending[rd_addr] is also a hazard. The writeback bypass applies here too.
- Structural hazard: is_muldiv && md_busy.
- id_ready = (!ex_valid || ex_ready) && !hazard && !structural && !flush. It is combinational from its inputs.
- Issue = id_valid && id_ready. On the next edge:
  - ex_valid=1.
  - ex_rd is captured; ex_muldiv is captured.
  - pending[rd_addr] is set if rd_valid and rd_addr!=0.
  - Latency decoder to execute: 1 cycle.
- Slot hold: if ex_valid && !ex_ready, the slot holds its value. If ex_ready && !issue, ex_valid goes to 0 on the next edge.
- Scoreboard clear:
  - wb_valid && wb_rd!=0 clears pending[wb_rd].
  - If an issue sets the same index in the same cycle, the set wins.
  - wb_valid with wb_rd=0 or a non-pending index has no effect.
- FSM states RUN and MD_BUSY:
  - RUN to MD_BUSY on issue with is_muldiv.
    - md_start pulses for that one edge (registered, aligned with ex_valid).
    - Counter loads DIV_LAT-1 if is_div, else MUL_LAT-1; md_busy=1.
  - In MD_BUSY the counter decrements each cycle. At 0 the FSM returns to RUN and md_busy=0 on that edge.
  - Non-M instructions without hazards keep issuing during MD_BUSY.
- Flush (highest priority after rst):
  - id_ready=0 that cycle and ex_valid goes to 0.
  - pending is cleared to 0.
  - The counter is cleared, FSM goes to RUN, md_busy=0.
  - A wb_valid in the same cycle is absorbed by the clear.
- stall_cycles increments on id_valid && !id_ready && !flush and saturates at 0xFFFFFFFF.
- x0 is never pending, never a hazard, and never an ex_rd target.

Decomposition:
- Shared core package holds:
  - opcode constants: OP_R 7'b0110011, OP_I 7'b0010011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM;
  - FUNC7_MULDIV 7'b0000001;
  - FSM state encoding (RUN=1'b0, MD_BUSY=1'b1).
- One sub-module, scoreboard (32-bit set/clear register with hazard lookup ports). The FSM, slot register and counters stay in issue_ctrl.

Test Plan:
- Dependent issue: issue ADD x5 (rd=5). Next cycle, ADD x6,x5,x1 with ex_ready=1 and no wb gives id_ready=0 and pending[5]=1. Then wb_valid=1 with wb_rd=5 in the same cycle gives id_ready=1, and the next edge shows ex_rd=6 and pending[5]=0.
- Back-pressure: ex_ready=0 with ex_valid=1 and new independent id_valid gives id_ready=0 and ex_rd held. stall_cycles increments by 1 per cycle, reaching 3 after 3 cycles.
- Division occupancy: issue DIV x7 (is_div=1), giving md_start=1 for one cycle. A MUL arriving afterward stalls exactly 33 cycles from md_start before issuing. An independent ADD issued during the busy window is accepted immediately.
- MUL latency: MUL x8 then MUL x9 (independent) are issued 4 cycles apart; md_busy falls on the 4th edge after md_start.
- Flush mid-op: during DIV with pending={5,7}, flush=1 gives pending=0, md_busy=0 and ex_valid=0 next cycle. A DIV on the following cycle issues without stall.
- x0 and same-cycle set/clear:
  - ADD x0 leaves pending=0.
  - Issue rd=3 while wb_rd=3 leaves pending[3]=1.
  - Reset asserted mid-stall zeroes all outputs next edge.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// Shared core definitions for the RV32IM issue stage.
//   - Major opcode and M-extension func7 constants used by the decoder.
//   - Encoding of the mul/div occupancy FSM.
//   - reg_onehot(): register index to one-hot mask. x0 maps to an
//     all-zero mask, so it can never be marked pending.
package issue_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic [31:0] reg_onehot(input logic [4:0] idx);
    logic [31:0] mask;
    mask = 32'd1 << idx;
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// 32-entry register scoreboard with hazard lookup.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : clear every pending bit (wins over set and clear)
//   set_en/set_idx  : mark a destination as in flight
//   clr_en/clr_idx  : writeback retiring a destination (also the bypass)
//   rs1_*/rs2_*/rd_*: decoder fields looked up for RAW / WAW hazards
//   hazard          : any source or destination collides with a pending write
//   pending         : current scoreboard bits, bit 0 always 0
module issue_ctrl_scoreboard
  import issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic [4:0]  rs1_addr,
  input  logic        rs1_valid,
  input  logic [4:0]  rs2_addr,
  input  logic        rs2_valid,
  input  logic [4:0]  rd_addr,
  input  logic        rd_valid,
  output logic        hazard,
  output logic [31:0] pending
);

  logic [31:0] pending_q;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // A writeback landing this cycle resolves the dependency, so it masks the hit.
  function automatic logic reg_hit(input logic [31:0] pend, input logic used,
                                   input logic [4:0] idx, input logic wb_en,
                                   input logic [4:0] wb_idx);
    return used && (idx != 5'd0) && pend[idx] && !(wb_en && (wb_idx == idx));
  endfunction

  assign hazard = reg_hit(pending_q, rs1_valid, rs1_addr, clr_en, clr_idx)
                | reg_hit(pending_q, rs2_valid, rs2_addr, clr_en, clr_idx)
                | reg_hit(pending_q, rd_valid,  rd_addr,  clr_en, clr_idx);

  assign set_mask = set_en ? reg_onehot(set_idx) : '0;
  assign clr_mask = clr_en ? reg_onehot(clr_idx) : '0;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pending_q <= '0;
    end else begin
      // Set is applied after clear so a same-index issue keeps the bit.
      pending_q <= (pending_q & ~clr_mask) | set_mask;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/issue_ctrl.sv
// Issue/stall controller between the RV32IM decoder and execute.
//   clk, rst                 : clock, synchronous active-high reset
//   id_valid/id_ready        : decoder handshake (id_ready is combinational)
//   rs1_*, rs2_*, rd_*       : decoder register fields and use flags
//   is_muldiv, is_div        : M-extension op and its div/rem class
//   ex_valid/ex_ready        : registered issue slot handshake to execute
//   ex_rd, ex_muldiv         : slot payload (ex_rd is 0 when rd is unused)
//   md_start, md_busy        : mul/div launch pulse and occupancy
//   wb_valid, wb_rd          : writeback retiring a scoreboard entry
//   flush                    : redirect; squashes slot, scoreboard, mul/div
//   pending                  : scoreboard bits
//   stall_cycles             : saturating count of stalled decoder cycles
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  rs1_addr,
  input  logic        rs1_valid,
  input  logic [4:0]  rs2_addr,
  input  logic        rs2_valid,
  input  logic [4:0]  rd_addr,
  input  logic        rd_valid,
  input  logic        is_muldiv,
  input  logic        is_div,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [4:0]  ex_rd,
  output logic        ex_muldiv,
  output logic        md_start,
  output logic        md_busy,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic [31:0] pending,
  output logic [31:0] stall_cycles
);

  logic             hazard;
  logic             structural;
  logic             issue;
  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  issue_ctrl_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .set_en    (issue && rd_valid),
    .set_idx   (rd_addr),
    .clr_en    (wb_valid),
    .clr_idx   (wb_rd),
    .rs1_addr  (rs1_addr),
    .rs1_valid (rs1_valid),
    .rs2_addr  (rs2_addr),
    .rs2_valid (rs2_valid),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .hazard    (hazard),
    .pending   (pending)
  );

  assign md_busy    = (state_q == MD_BUSY);
  assign structural = is_muldiv && md_busy;
  assign id_ready   = (!ex_valid || ex_ready) && !hazard && !structural && !flush;
  assign issue      = id_valid && id_ready;

  // Occupancy FSM: the counter holds the remaining busy cycles minus one, so
  // md_busy drops on the LAT-th edge after the launch edge.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (issue && is_muldiv) begin
          state_d = MD_BUSY;
          cnt_d   = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
    if (flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Issue slot. ex_rd/ex_muldiv keep their last payload once the slot drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_muldiv <= 1'b0;
      md_start  <= 1'b0;
    end else begin
      md_start <= issue && is_muldiv;
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (issue) begin
        ex_valid  <= 1'b1;
        ex_rd     <= rd_valid ? rd_addr : 5'd0;
        ex_muldiv <= is_muldiv;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (id_valid && !id_ready && !flush && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios followed by random
// traffic, all compared each cycle against a behavioural model that tracks
// the pending set, remaining mul/div busy cycles and the issue slot.
module tb_issue_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  rs1_addr;
  logic        rs1_valid;
  logic [4:0]  rs2_addr;
  logic        rs2_valid;
  logic [4:0]  rd_addr;
  logic        rd_valid;
  logic        is_muldiv;
  logic        is_div;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic        ex_muldiv;
  logic        md_start;
  logic        md_busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] pending;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .rs1_addr     (rs1_addr),
    .rs1_valid    (rs1_valid),
    .rs2_addr     (rs2_addr),
    .rs2_valid    (rs2_valid),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .is_muldiv    (is_muldiv),
    .is_div       (is_div),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_rd        (ex_rd),
    .ex_muldiv    (ex_muldiv),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .pending      (pending),
    .stall_cycles (stall_cycles)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state.
  bit     armed = 1'b0;
  bit     m_pend[32];
  int     m_busy_left;
  bit     m_exv;
  int     m_exrd;
  bit     m_exmd;
  bit     m_mdstart;
  longint m_stall;

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit src_hit(input bit used, input int idx);
    return used && idx != 0 && m_pend[idx] && !(wb_valid && int'(wb_rd) == idx);
  endfunction

  function automatic bit model_ready();
    bit blocked;
    blocked = src_hit(rs1_valid, int'(rs1_addr)) || src_hit(rs2_valid, int'(rs2_addr))
           || src_hit(rd_valid, int'(rd_addr)) || (is_muldiv && m_busy_left > 0);
    return (!m_exv || ex_ready) && !blocked && !flush;
  endfunction

  // One clock: inputs are already driven; compare, then advance the model.
  task automatic tick();
    bit exp_ready;
    bit iss;
    #1;
    if (armed) begin
      check("ex_valid", ex_valid, m_exv);
      check("ex_rd", ex_rd, m_exrd);
      check("ex_muldiv", ex_muldiv, m_exmd);
      check("md_start", md_start, m_mdstart);
      check("md_busy", md_busy, m_busy_left > 0);
      check("pending", pending, pend_vec());
      check("stall_cycles", stall_cycles, m_stall[31:0]);
    end
    exp_ready = model_ready();
    if (armed && !rst) check("id_ready", id_ready, exp_ready);
    iss = id_valid && exp_ready;
    @(posedge clk);
    if (rst) begin
      armed = 1'b1;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_busy_left = 0;
      m_exv = 0; m_exrd = 0; m_exmd = 0; m_mdstart = 0; m_stall = 0;
    end else if (flush) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_busy_left = 0;
      m_exv = 0;
      m_mdstart = 0;
    end else begin
      if (id_valid && !exp_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (wb_valid && wb_rd != 0) m_pend[wb_rd] = 1'b0;
      if (iss && rd_valid && rd_addr != 0) m_pend[rd_addr] = 1'b1;
      m_mdstart = iss && is_muldiv;
      if (iss && is_muldiv) m_busy_left = is_div ? DIV_LAT : MUL_LAT;
      else if (m_busy_left > 0) m_busy_left--;
      if (iss) begin
        m_exv = 1; m_exrd = rd_valid ? int'(rd_addr) : 0; m_exmd = is_muldiv;
      end else if (ex_ready) begin
        m_exv = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; id_valid = 0; flush = 0; ex_ready = 1;
    rs1_addr = 0; rs1_valid = 0; rs2_addr = 0; rs2_valid = 0;
    rd_addr = 0; rd_valid = 0; is_muldiv = 0; is_div = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  task automatic op(input int rd, input bit rdv, input int rs1, input bit rs1v,
                    input int rs2, input bit rs2v, input bit md, input bit dv);
    id_valid = 1;
    rd_addr = 5'(rd);   rd_valid = rdv;
    rs1_addr = 5'(rs1); rs1_valid = rs1v;
    rs2_addr = 5'(rs2); rs2_valid = rs2v;
    is_muldiv = md;     is_div = dv;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint base;
    int waited;
    idle();
    rst = 1;
    @(negedge clk);
    tick();
    tick();
    idle();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_md_busy", md_busy, 0);

    // Dependent issue with same-cycle writeback bypass.
    op(5, 1, 0, 0, 0, 0, 0, 0);
    tick();
    op(6, 1, 5, 1, 1, 1, 0, 0);
    #1;
    check("dep_stall", id_ready, 0);
    check("dep_pend5", pending[5], 1);
    tick();
    wb_valid = 1; wb_rd = 5;
    #1;
    check("dep_bypass", id_ready, 1);
    tick();
    idle();
    check("dep_ex_rd", ex_rd, 6);
    check("dep_pend5_clr", pending[5], 0);

    // Back-pressure holds the slot and counts stall cycles.
    base = m_stall;
    ex_ready = 0;
    op(10, 1, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", id_ready, 0);
      tick();
      check("bp_hold_rd", ex_rd, 6);
    end
    check("bp_stall3", stall_cycles, 32'(base + 3));
    ex_ready = 1;
    tick();
    idle();
    tick();

    // Division occupancy: independent ADD goes, MUL waits DIV_LAT cycles.
    op(7, 1, 1, 1, 2, 1, 1, 1);
    tick();
    check("div_md_start", md_start, 1);
    op(11, 1, 1, 1, 0, 0, 0, 0);
    #1;
    check("div_add_ok", id_ready, 1);
    tick();
    check("div_md_start_pulse", md_start, 0);
    waited = 1;
    op(8, 1, 1, 1, 0, 0, 1, 0);
    for (int k = 0; k < 100; k++) begin
      #1;
      if (id_ready) break;
      tick();
      waited++;
    end
    check("div_wait", waited, DIV_LAT);
    tick();
    check("mul_md_start", md_start, 1);
    waited = 0;
    op(9, 1, 2, 1, 0, 0, 1, 0);
    for (int k = 0; k < 100; k++) begin
      #1;
      if (id_ready) break;
      tick();
      waited++;
    end
    check("mul_wait", waited, MUL_LAT);
    check("mul_busy_low", md_busy, 0);
    tick();
    idle();
    tick();

    // Flush in the middle of a division.
    flush = 1;
    tick();
    idle();
    op(5, 1, 0, 0, 0, 0, 0, 0);
    tick();
    op(7, 1, 0, 0, 0, 0, 1, 1);
    tick();
    idle();
    check("fl_pend_pre", pending, 32'h0000_00A0);
    check("fl_busy_pre", md_busy, 1);
    flush = 1;
    tick();
    idle();
    check("fl_pend", pending, 0);
    check("fl_busy", md_busy, 0);
    check("fl_ex_valid", ex_valid, 0);
    op(7, 1, 0, 0, 0, 0, 1, 1);
    #1;
    check("fl_div_ready", id_ready, 1);
    tick();
    idle();
    check("fl_div_start", md_start, 1);

    // x0 destination and same-cycle set/clear.
    op(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    check("x0_pend", pending & 32'hFFFF_FF7F, 0);
    op(3, 1, 0, 0, 0, 0, 0, 0);
    wb_valid = 1; wb_rd = 3;
    tick();
    idle();
    check("set_wins", pending[3], 1);

    // Reset while stalled.
    ex_ready = 0;
    op(12, 1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1;
    tick();
    idle();
    check("rst2_ex_valid", ex_valid, 0);
    check("rst2_ex_rd", ex_rd, 0);
    check("rst2_md_busy", md_busy, 0);
    check("rst2_md_start", md_start, 0);
    check("rst2_pending", pending, 0);
    check("rst2_stall", stall_cycles, 0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      id_valid  = ($urandom_range(0, 3) != 0);
      ex_ready  = ($urandom_range(0, 3) != 0);
      rs1_addr  = 5'($urandom_range(0, 7));
      rs1_valid = 1'($urandom_range(0, 1));
      rs2_addr  = 5'($urandom_range(0, 7));
      rs2_valid = 1'($urandom_range(0, 1));
      rd_addr   = 5'($urandom_range(0, 7));
      rd_valid  = ($urandom_range(0, 3) != 0);
      is_muldiv = ($urandom_range(0, 4) == 0);
      is_div    = 1'($urandom_range(0, 1));
      wb_valid  = ($urandom_range(0, 9) < 4);
      wb_rd     = 5'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
